// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into one APB SETUP/ACCESS
// transfer each and reports read data plus error/timeout on a one-cycle strobe.
module apb_master_bridge #(
    parameter int AWIDTH  = 4,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t            state_q;
    logic              psel_q, penable_q, pwrite_q;
    logic [AWIDTH-1:0] paddr_q;
    logic [DWIDTH-1:0] pwdata_q, rsp_rdata_q;
    logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [CW-1:0]     cnt_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_rdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q      <= cmd_write;
                        paddr_q       <= cmd_addr;
                        pwdata_q      <= cmd_wdata;
                        psel_q        <= 1'b1;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_err_q     <= PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (TIMEOUT > 0 && cnt_q == LIMIT) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (cnt_q != '1) begin
                        // saturate so a disabled timeout never wraps the counter
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !PRESET;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge against a small register-file APB slave
// with programmable wait states, slave error and stuck-PREADY behaviour.
module tb_apb_master_bridge;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       PSEL, PENABLE, PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // slave controls
    int         wait_cycles = 0;
    logic       stuck       = 1'b0;
    logic       err_ready   = 1'b0;
    logic       err_wait    = 1'b0;
    int         acc_cnt     = 0;
    logic [7:0] mem [16];

    apb_master_bridge #(.AWIDTH(4), .DWIDTH(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    assign PREADY  = !stuck && (acc_cnt >= wait_cycles);
    assign PSLVERR = PREADY ? err_ready : err_wait;
    assign PRDATA  = PREADY ? mem[PADDR] : 8'hEE;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (PRESET) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hC0 | 8'(i);
        end else if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
            mem[PADDR] <= PWDATA;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Issue one command and follow it to its response. k counts edges after accept.
    task automatic do_xfer(input string tag, input logic w, input logic [3:0] a,
                           input logic [7:0] d, input int exp_k, input logic [7:0] exp_rd,
                           input logic exp_err, input logic exp_to);
        int k = 0;
        int nsel = 0, nen = 0, unstable = 0;
        check_eq({tag, "_ready"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        tick();
        cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
        check_eq({tag, "_setup"}, {PSEL, PENABLE, cmd_ready}, 3'b100);
        check_eq({tag, "_flagclr"}, {rsp_err, rsp_timeout}, 2'b00);
        nsel += int'(PSEL); nen += int'(PENABLE);
        while (!rsp_valid && k < 60) begin
            tick();
            k++;
            if (!rsp_valid) begin
                nsel += int'(PSEL); nen += int'(PENABLE);
                if (PADDR !== a || PWRITE !== w || (w && PWDATA !== d)) unstable++;
            end
        end
        check_eq({tag, "_lat"}, k, exp_k);
        check_eq({tag, "_psel"}, nsel, exp_k);
        check_eq({tag, "_pen"}, nen, exp_k - 1);
        check_eq({tag, "_stable"}, unstable, 0);
        check_eq({tag, "_rsp"}, {rsp_valid, PSEL, PENABLE, rsp_err, rsp_timeout, rsp_rdata},
                 {3'b100, exp_err, exp_to, exp_rd});
        tick();
        check_eq({tag, "_idle"}, {rsp_valid, cmd_ready, rsp_err, rsp_timeout},
                 {2'b01, exp_err, exp_to});
    endtask

    initial begin
        int k;
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        tick(); tick();
        check_eq("rst_outs", {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout,
                              cmd_ready}, 7'b0);
        check_eq("rst_data", {PADDR, PWDATA, rsp_rdata}, 20'h0);
        PRESET = 1'b0;
        #1;
        check_eq("rst_ready", cmd_ready, 1'b1);
        tick();

        // write, zero wait states
        do_xfer("wr0", 1'b1, 4'h2, 8'hA5, 2, 8'h00, 1'b0, 1'b0);
        check_eq("wr0_mem", mem[2], 8'hA5);

        // read with three wait states
        wait_cycles = 3;
        do_xfer("rd3", 1'b0, 4'h5, 8'h00, 5, 8'hC5, 1'b0, 1'b0);
        wait_cycles = 0;

        // slave error on completion
        err_ready = 1'b1;
        do_xfer("serr", 1'b0, 4'hF, 8'h00, 2, 8'h00, 1'b1, 1'b0);
        err_ready = 1'b0;

        // PSLVERR asserted only during wait cycles is ignored
        wait_cycles = 2; err_wait = 1'b1;
        do_xfer("werr", 1'b0, 4'hF, 8'h00, 4, 8'hCF, 1'b0, 1'b0);
        wait_cycles = 0; err_wait = 1'b0;

        // timeout: 16 ACCESS cycles then abort
        stuck = 1'b1;
        do_xfer("tmo", 1'b0, 4'h3, 8'h00, 17, 8'h00, 1'b1, 1'b1);
        stuck = 1'b0;
        do_xfer("post", 1'b0, 4'h3, 8'h00, 2, 8'hC3, 1'b0, 1'b0);

        // PREADY arriving on the limit cycle still completes normally
        wait_cycles = 15;
        do_xfer("edge", 1'b0, 4'h4, 8'h00, 17, 8'hC4, 1'b0, 1'b0);
        wait_cycles = 0;

        // back-to-back with cmd_valid held high
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h1; cmd_wdata = 8'h11;
        tick();
        cmd_write = 1'b0; cmd_wdata = 8'h00;
        k = 0;
        while (!rsp_valid && k < 60) begin tick(); k++; end
        check_eq("b2b_lat1", k, 2);
        tick();
        check_eq("b2b_gap", {PSEL, cmd_ready}, 2'b01);
        tick();
        check_eq("b2b_acc2", {PSEL, PENABLE, PWRITE, PADDR}, {3'b100, 4'h1});
        cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 60) begin tick(); k++; end
        check_eq("b2b_lat2", k, 2);
        check_eq("b2b_rd", {rsp_err, rsp_rdata}, {1'b0, 8'h11});
        tick();

        // reset while stuck in ACCESS
        stuck = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h6;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("mid_access", {PSEL, PENABLE}, 2'b11);
        PRESET = 1'b1;
        tick();
        check_eq("mid_rst", {PSEL, PENABLE, rsp_valid}, 3'b000);
        PRESET = 1'b0;
        stuck = 1'b0;
        #1;
        check_eq("mid_ready", cmd_ready, 1'b1);
        tick();
        check_eq("mid_norsp", {rsp_valid, PSEL, cmd_ready}, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
